// File: rtl/decode_sequencer.sv
// -----------------------------------------------------------------------------
// decode_sequencer
//
// Decode-stage front end. Fetched instructions arrive over a valid/ready
// handshake and are classified by opcode into an immediate format. The
// immediate is extended on the way in, so each buffered entry is stored fully
// decoded. A 2-entry skid buffer (output register plus skid register) keeps
// in_ready a function of registered state only. Fetch back-pressure therefore
// never has a combinational path from out_ready.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (empties the buffer, clears data)
//   flush        discard every buffered entry and any offered instruction
//   in_valid     fetch offers in_inst / in_pc
//   in_ready     decode can take an instruction (state != FULL)
//   in_inst      raw instruction word
//   in_pc        PC of in_inst
//   out_valid    decoded entry available (state != EMPTY)
//   out_ready    execute accepts the entry
//   out_inst     instruction word of the head entry
//   out_pc       PC of the head entry
//   out_op_type  immediate format: I=0, S=2, B=3, U=4, J=5, R=6
//   out_imm      extended immediate for out_op_type
//   out_illegal  opcode not recognised
// -----------------------------------------------------------------------------
module decode_sequencer #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_op_type,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_R = 3'd6;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      op_type;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // Value both storage registers take on reset.
  localparam entry_t RESET_ENTRY = '{
    inst:    '0,
    pc:      '0,
    op_type: FMT_R,
    imm:     '0,
    illegal: 1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Immediate extender; R-format (and anything unrecognised) yields zero.
  function automatic logic [XLEN-1:0] ext_imm(input logic [2:0]      fmt,
                                              input logic [XLEN-1:0] inst);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'b0};
      FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Classify the opcode and build a complete decoded entry.
  function automatic entry_t decode_entry(input logic [XLEN-1:0] inst,
                                          input logic [XLEN-1:0] pc);
    entry_t e;
    e.inst    = inst;
    e.pc      = pc;
    e.op_type = FMT_R;
    e.illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: e.op_type = FMT_I;
      OPC_STORE:                                 e.op_type = FMT_S;
      OPC_BRANCH:                                e.op_type = FMT_B;
      OPC_LUI, OPC_AUIPC:                        e.op_type = FMT_U;
      OPC_JAL:                                   e.op_type = FMT_J;
      OPC_OP:                                    e.op_type = FMT_R;
      default: begin
        e.op_type = FMT_R;
        e.illegal = 1'b1;
      end
    endcase
    e.imm = ext_imm(e.op_type, inst);
    return e;
  endfunction

  state_t state_q, state_d;
  entry_t out_q,   out_d;
  entry_t skid_q,  skid_d;
  entry_t in_dec;
  logic   acc;
  logic   pop;

  // Handshake flags depend only on the registered state.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);

  assign acc    = in_valid  & in_ready;
  assign pop    = out_valid & out_ready;
  assign in_dec = decode_entry(in_inst, in_pc);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          out_d   = in_dec;
        end
      end
      ST_ONE: begin
        if (acc && !pop) begin
          state_d = ST_FULL;
          skid_d  = in_dec;
        end else if (acc && pop) begin
          out_d = in_dec;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush empties the buffer; the offered instruction is dropped and the
    // stale data registers are left as they are (out_valid masks them).
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = out_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= RESET_ENTRY;
      skid_q  <= RESET_ENTRY;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_inst    = out_q.inst;
  assign out_pc      = out_q.pc;
  assign out_op_type = out_q.op_type;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

- Decode-stage front end of the core: accepts fetched instructions over a valid/ready handshake.
- Classifies each opcode into the immediate-format code and drives the immediate extender with it.
- Registers instruction, PC, format code, extended immediate and an illegal flag toward the execute stage.
- A 2-entry skid buffer keeps `in_ready` a pure function of registered state, so fetch back-pressure is never combinational from `out_ready`.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: discard all buffered and in-flight instructions (branch redirect).
- `in_valid` input 1: fetch offers an instruction.
- `in_ready` output 1: decode can take an instruction this cycle.
- `in_inst` input 32: raw instruction word.
- `in_pc` input 32: PC of `in_inst`.
- `out_valid` output 1: decoded entry available.
- `out_ready` input 1: execute accepts the entry.
- `out_inst` output 32: instruction word of the entry.
- `out_pc` output 32: PC of the entry.
- `out_op_type` output 3: immediate format, I=0, S=2, B=3, U=4, J=5, R=6.
- `out_imm` output 32: extended immediate for `out_op_type`.
- `out_illegal` output 1: opcode not recognised.

## Operation
- **Opcode map (`inst[6:0]`):**
  - I-format (0): 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM.
  - S-format (2): 0100011 STORE.
  - B-format (3): 1100011 BRANCH.
  - U-format (4): 0110111 LUI, 0010111 AUIPC.
  - J-format (5): 1101111 JAL.
  - R-format (6): 0110011 OP.
  - Any other value: op_type 6, imm 0, illegal 1.
  - Codes 1 and 7 are never produced.
- **Immediate construction:** identical to the core's extender.
  - I: sign-extended `inst[31:20]`.
  - S: sign-extended `{inst[31:25],inst[11:7]}`.
  - B: sign-extended `{inst[31],inst[7],inst[30:25],inst[11:8],0}`.
  - U: `{inst[31:12],12'b0}`.
  - J: sign-extended `{inst[31],inst[19:12],inst[20],inst[30:21],0}`.
  - R: 0.
- **Decode point:** decode happens on the input side; each entry is stored already decoded (inst, pc, op_type, imm, illegal).
- **States:**
  - EMPTY: no entries.
  - ONE: output register valid.
  - FULL: output register valid plus skid register valid.
- **Outputs per state:**
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
- **Transitions** (acc = `in_valid & in_ready`, pop = `out_valid & out_ready`):
  - EMPTY: acc → ONE, with the decoded input loaded into the output register.
  - ONE, acc & !pop → FULL: input goes to the skid register.
  - ONE, acc & pop → ONE: output register loaded with the input.
  - ONE, !acc & pop → EMPTY.
  - ONE, !acc & !pop → ONE, output held.
  - FULL, pop → ONE: skid register moves to the output register. No accept is possible in FULL.
  - FULL, !pop → FULL, all held.
- **Ordering:** strictly FIFO; no entry is ever dropped or duplicated except on `flush`/`rst`.
- **Flush:** highest priority after `rst`. Next state is EMPTY regardless of acc/pop; any instruction offered in the flush cycle is discarded, even though `in_ready` was high.
- **Reset:**
  - state EMPTY, so `out_valid`=0 and `in_ready`=1 from the first cycle after reset.
  - `out_inst`, `out_pc`, `out_imm` = 0.
  - `out_op_type` = 6.
  - `out_illegal` = 0.
  - Skid register cleared to the same values.
- **Reset mid-operation:** all entries are lost, identical to flush.

## Timing
- Latency: 1 cycle, from accept edge to `out_valid` high.
- Throughput: 1 instruction/cycle while `out_ready` stays high.
- Stall stability: while `out_valid & !out_ready`, every `out_*` signal is stable.
- `in_ready`: registered-state only, with no combinational path from `out_ready` or `in_valid`.
- Stall response: after a single stall cycle with continuous input, `in_ready` drops the following cycle (FULL). On the pop, it rises again the cycle after.
- `out_*` timing: all outputs come straight from registers; there is no combinational decode on the output path.

## Test plan
- **Single instruction:** reset, then send `0xFFF00093` (addi x1,x0,-1) at pc `0x100` with `out_ready`=1.
  - Next cycle: `out_valid`=1, op_type 0, imm `0xFFFFFFFF`, pc `0x100`, illegal 0.
  - Cycle after: `out_valid`=0.
- **Back-to-back stream:** `0x0020A423` (sw), `0x123452B7` (lui), `0xFFDFF06F` (jal x0,-4), `out_ready`=1.
  - Output one per cycle, in order.
  - op_type 2/4/5; imm `0x00000008`/`0x12345000`/`0xFFFFFFFC`.
- **Back-pressure:** hold `out_ready`=0, stream 3 instructions.
  - Two are accepted; `in_ready`=0 in the third cycle; outputs held stable.
  - Release `out_ready`: entries drain in order; the third is accepted one cycle after the first pop.
- **Illegal opcode:** `0x00000000` → op_type 6, imm 0, illegal 1.
  - `0x00B50533` (add) → op_type 6, imm 0, illegal 0.
- **Flush:** FULL state with `in_valid`=1, assert `flush` one cycle.
  - Next cycle: `out_valid`=0, `in_ready`=1.
  - The flush-cycle input never appears at the output.
- **Reset mid-stream:** assert `rst` while in ONE/FULL.
  - Next cycle: `out_valid`=0, op_type 6, imm 0, `in_ready`=1.
